// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch word reads against LSB loads/stores
// and turns each request into 1/2/4 single-byte RAM cycles with a one-cycle ok pulse.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_MSB = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        enable_from_if,
  input  logic [31:0] addr_from_if,
  output logic        ok_to_if,
  output logic [31:0] inst_to_if,
  input  logic        enable_from_lsb,
  input  logic        read_or_write_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [31:0] data_from_lsb,
  input  logic [2:0]  width_from_lsb,
  output logic        ok_to_lsb,
  output logic [31:0] data_to_lsb,
  input  logic        mispredict,
  output logic [1:0]  dbg_state
);

  // Handshake: a client holds enable until it sees its ok pulse; while ok is high the
  // still-asserted enable belongs to the finished access and is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n, width, width_n, nxt_idx;
  logic [1:0]  cap_idx;
  logic [31:0] addr_q, addr_n, data_q, data_n, asm_q, asm_n;
  logic        is_lsb, is_lsb_n;
  logic        wr_q, wr_n, ok_if_n, ok_lsb_n;
  logic [31:0] mem_a_n, inst_n, dlsb_n;
  logic [7:0]  mem_dout_n;
  logic        lsb_blocked, lsb_req, if_req;

  assign nxt_idx     = cnt + 3'd1;
  assign cap_idx     = 2'(cnt - 3'd1);
  assign lsb_blocked = read_or_write_from_lsb && (addr_from_lsb[17:16] == IO_ADDR_MSB)
                       && io_buffer_full;
  assign lsb_req     = enable_from_lsb && !ok_to_lsb && !lsb_blocked;
  assign if_req      = enable_from_if && !ok_to_if;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    width_n    = width;
    addr_n     = addr_q;
    data_n     = data_q;
    asm_n      = asm_q;
    is_lsb_n   = is_lsb;
    wr_n       = wr_q;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    ok_if_n    = 1'b0;
    ok_lsb_n   = 1'b0;
    inst_n     = inst_to_if;
    dlsb_n     = data_to_lsb;
    case (state)
      IDLE: begin
        if (!mispredict && lsb_req) begin
          addr_n   = addr_from_lsb;
          data_n   = data_from_lsb;
          width_n  = width_from_lsb;
          is_lsb_n = 1'b1;
          cnt_n    = 3'd0;
          asm_n    = 32'h0;
          mem_a_n  = addr_from_lsb;
          if (read_or_write_from_lsb) begin
            state_n    = WRITE;
            wr_n       = 1'b1;
            mem_dout_n = data_from_lsb[7:0];
          end else begin
            state_n = READ;
            wr_n    = 1'b0;
          end
        end else if (!mispredict && if_req) begin
          addr_n   = addr_from_if;
          width_n  = 3'd4;
          is_lsb_n = 1'b0;
          cnt_n    = 3'd0;
          asm_n    = 32'h0;
          mem_a_n  = addr_from_if;
          state_n  = READ;
          wr_n     = 1'b0;
        end
      end
      READ: begin
        if (mispredict) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          mem_a_n = 32'h0;
          wr_n    = 1'b0;
        end else begin
          // Byte cnt-1 was addressed two edges ago and sits on mem_din now.
          if (cnt != 3'd0) asm_n[{cap_idx, 3'b000} +: 8] = mem_din;
          if (cnt == width) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            mem_a_n = 32'h0;
            if (is_lsb) begin
              ok_lsb_n = 1'b1;
              dlsb_n   = asm_n;
            end else begin
              ok_if_n = 1'b1;
              inst_n  = asm_n;
            end
          end else begin
            cnt_n = nxt_idx;
            if (nxt_idx < width) mem_a_n = addr_q + 32'(nxt_idx);
          end
        end
      end
      WRITE: begin
        // Stores are committed, so mispredict does not interrupt them.
        if (nxt_idx == width) begin
          state_n  = IDLE;
          cnt_n    = 3'd0;
          mem_a_n  = 32'h0;
          wr_n     = 1'b0;
          ok_lsb_n = 1'b1;
        end else begin
          cnt_n      = nxt_idx;
          mem_a_n    = addr_q + 32'(nxt_idx);
          mem_dout_n = 8'(data_q >> {nxt_idx, 3'b000});
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      width       <= 3'd0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      asm_q       <= 32'h0;
      is_lsb      <= 1'b0;
      wr_q        <= 1'b0;
      mem_a       <= 32'h0;
      mem_dout    <= 8'h0;
      ok_to_if    <= 1'b0;
      ok_to_lsb   <= 1'b0;
      inst_to_if  <= 32'h0;
      data_to_lsb <= 32'h0;
    end else if (rdy) begin
      state       <= state_n;
      cnt         <= cnt_n;
      width       <= width_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      asm_q       <= asm_n;
      is_lsb      <= is_lsb_n;
      wr_q        <= wr_n;
      mem_a       <= mem_a_n;
      mem_dout    <= mem_dout_n;
      ok_to_if    <= ok_if_n;
      ok_to_lsb   <= ok_lsb_n;
      inst_to_if  <= inst_n;
      data_to_lsb <= dlsb_n;
    end
  end

  assign mem_wr    = wr_q & rdy;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: arbitration, byte serialisation, I/O stall,
// mispredict, rdy freeze and asynchronous reset.
module tb_mem_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, mispredict;
  logic [7:0]  mem_din = 8'h0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        enable_from_if, ok_to_if;
  logic [31:0] addr_from_if, inst_to_if;
  logic        enable_from_lsb, read_or_write_from_lsb, ok_to_lsb;
  logic [31:0] addr_from_lsb, data_from_lsb, data_to_lsb;
  logic [2:0]  width_from_lsb;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sw_bytes [4];

  mem_ctrl #(.IO_ADDR_MSB(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .enable_from_if(enable_from_if), .addr_from_if(addr_from_if),
    .ok_to_if(ok_to_if), .inst_to_if(inst_to_if),
    .enable_from_lsb(enable_from_lsb), .read_or_write_from_lsb(read_or_write_from_lsb),
    .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
    .width_from_lsb(width_from_lsb), .ok_to_lsb(ok_to_lsb), .data_to_lsb(data_to_lsb),
    .mispredict(mispredict), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Read-only RAM image; data appears the cycle after its address.
  function automatic logic [7:0] ram_read(input logic [31:0] a);
    case (a)
      32'h0000: return 8'hEF;
      32'h0001: return 8'hBE;
      32'h0002: return 8'hAD;
      32'h0003: return 8'hDE;
      32'h1000: return 8'h11;
      32'h1001: return 8'h22;
      32'h1002: return 8'h33;
      32'h1003: return 8'h44;
      32'h2000: return 8'h34;
      32'h2001: return 8'h12;
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge clk) mem_din <= ram_read(mem_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    sw_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; mispredict = 1'b0;
    enable_from_if = 1'b0; addr_from_if = 32'h0;
    enable_from_lsb = 1'b0; read_or_write_from_lsb = 1'b0;
    addr_from_lsb = 32'h0; data_from_lsb = 32'h0; width_from_lsb = 3'd0;
    repeat (2) tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_ok_if", 32'(ok_to_if), 32'h0);
    check("rst_ok_lsb", 32'(ok_to_lsb), 32'h0);
    check("rst_inst", inst_to_if, 32'h0);
    check("rst_data", data_to_lsb, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b1;
    tick();

    // LW 0x1000
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b0;
    addr_from_lsb = 32'h1000; width_from_lsb = 3'd4;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lw_addr", mem_a, 32'h1000 + k);
      check("lw_wr", 32'(mem_wr), 32'h0);
    end
    tick();
    check("lw_ok_early", 32'(ok_to_lsb), 32'h0);
    tick();
    check("lw_ok", 32'(ok_to_lsb), 32'h1);
    check("lw_data", data_to_lsb, 32'h44332211);
    check("lw_mem_a_clr", mem_a, 32'h0);
    tick();
    check("lw_ok_once", 32'(ok_to_lsb), 32'h0);
    check("lw_no_dup", 32'(dbg_state), 32'(S_IDLE));
    enable_from_lsb = 1'b0;
    tick();

    // SB 0x41 to I/O with buffer full for 3 cycles
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1;
    addr_from_lsb = 32'h30000; width_from_lsb = 3'd1; data_from_lsb = 32'h41;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("io_stall_wr", 32'(mem_wr), 32'h0);
      check("io_stall_state", 32'(dbg_state), 32'(S_IDLE));
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_wr", 32'(mem_wr), 32'h1);
    check("io_addr", mem_a, 32'h30000);
    check("io_dout", 32'(mem_dout), 32'h41);
    tick();
    check("io_ok", 32'(ok_to_lsb), 32'h1);
    check("io_wr_off", 32'(mem_wr), 32'h0);
    check("io_a_clr", mem_a, 32'h0);
    tick();
    check("io_ok_once", 32'(ok_to_lsb), 32'h0);
    enable_from_lsb = 1'b0;
    tick();

    // Simultaneous fetch 0x0 and LH 0x2000
    enable_from_if = 1'b1; addr_from_if = 32'h0;
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b0;
    addr_from_lsb = 32'h2000; width_from_lsb = 3'd2; data_from_lsb = 32'h0;
    tick();
    check("arb_lsb_first", mem_a, 32'h2000);
    tick();
    check("lh_addr1", mem_a, 32'h2001);
    tick();
    check("lh_ok_early", 32'(ok_to_lsb), 32'h0);
    tick();
    check("lh_ok", 32'(ok_to_lsb), 32'h1);
    check("lh_data", data_to_lsb, 32'h00001234);
    check("lh_if_wait", 32'(ok_to_if), 32'h0);
    tick();
    check("fetch_accept", 32'(dbg_state), 32'(S_READ));
    check("fetch_addr0", mem_a, 32'h0);
    check("lh_ok_once", 32'(ok_to_lsb), 32'h0);
    enable_from_lsb = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("fetch_addr", mem_a, 32'(k));
    end
    tick();
    check("fetch_ok_early", 32'(ok_to_if), 32'h0);
    tick();
    check("fetch_ok", 32'(ok_to_if), 32'h1);
    check("fetch_inst", inst_to_if, 32'hDEADBEEF);
    tick();
    check("fetch_ok_once", 32'(ok_to_if), 32'h0);
    enable_from_if = 1'b0;
    tick();

    // Mispredict at E2 of a fetch, then held for one idle edge
    enable_from_if = 1'b1; addr_from_if = 32'h0;
    tick();
    check("mp_start", 32'(dbg_state), 32'(S_READ));
    tick();
    mispredict = 1'b1;
    tick();
    check("mp_idle", 32'(dbg_state), 32'(S_IDLE));
    check("mp_no_ok", 32'(ok_to_if), 32'h0);
    check("mp_a_clr", mem_a, 32'h0);
    tick();
    check("mp_no_accept", 32'(dbg_state), 32'(S_IDLE));
    mispredict = 1'b0; enable_from_if = 1'b0;
    tick();
    check("mp_no_ok_late", 32'(ok_to_if), 32'h0);

    // SW 0xAABBCCDD with mispredict from E1: must complete
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1;
    addr_from_lsb = 32'h4000; width_from_lsb = 3'd4; data_from_lsb = 32'hAABBCCDD;
    tick();
    check("sw_wr0", 32'(mem_wr), 32'h1);
    check("sw_a0", mem_a, 32'h4000);
    check("sw_d0", 32'(mem_dout), 32'(sw_bytes[0]));
    mispredict = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("sw_wr", 32'(mem_wr), 32'h1);
      check("sw_a", mem_a, 32'h4000 + k);
      check("sw_d", 32'(mem_dout), 32'(sw_bytes[k]));
    end
    tick();
    check("sw_ok", 32'(ok_to_lsb), 32'h1);
    check("sw_wr_off", 32'(mem_wr), 32'h0);
    mispredict = 1'b0;
    tick();
    enable_from_lsb = 1'b0;
    tick();

    // LW with rdy low for 2 cycles right after acceptance
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b0;
    addr_from_lsb = 32'h1000; width_from_lsb = 3'd4;
    tick();
    check("frz_a0", mem_a, 32'h1000);
    rdy = 1'b0;
    repeat (2) begin
      tick();
      check("frz_hold_a", mem_a, 32'h1000);
      check("frz_hold_state", 32'(dbg_state), 32'(S_READ));
    end
    rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("frz_addr", mem_a, 32'h1000 + k);
    end
    tick();
    check("frz_ok_early", 32'(ok_to_lsb), 32'h0);
    tick();
    check("frz_ok", 32'(ok_to_lsb), 32'h1);
    check("frz_data", data_to_lsb, 32'h44332211);
    tick();
    enable_from_lsb = 1'b0;
    tick();

    // SH with rdy low mid-write: mem_wr gated combinationally
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1;
    addr_from_lsb = 32'h5000; width_from_lsb = 3'd2; data_from_lsb = 32'h0000BEEF;
    tick();
    check("sh_wr0", 32'(mem_wr), 32'h1);
    rdy = 1'b0;
    #1;
    check("sh_gate_wr", 32'(mem_wr), 32'h0);
    tick();
    check("sh_gate_hold", mem_a, 32'h5000);
    rdy = 1'b1;
    #1;
    check("sh_ungate_wr", 32'(mem_wr), 32'h1);
    tick();
    check("sh_a1", mem_a, 32'h5001);
    check("sh_d1", 32'(mem_dout), 32'hBE);
    tick();
    check("sh_ok", 32'(ok_to_lsb), 32'h1);
    tick();
    enable_from_lsb = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write, then a clean fetch
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1;
    addr_from_lsb = 32'h6000; width_from_lsb = 3'd4; data_from_lsb = 32'h01020304;
    tick();
    tick();
    check("rw_pre_wr", 32'(mem_wr), 32'h1);
    rst = 1'b0;
    #1;
    check("rw_wr", 32'(mem_wr), 32'h0);
    check("rw_a", mem_a, 32'h0);
    check("rw_ok_lsb", 32'(ok_to_lsb), 32'h0);
    check("rw_ok_if", 32'(ok_to_if), 32'h0);
    check("rw_state", 32'(dbg_state), 32'(S_IDLE));
    enable_from_lsb = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    enable_from_if = 1'b1; addr_from_if = 32'h0;
    tick();
    check("rf_addr0", mem_a, 32'h0);
    repeat (4) tick();
    check("rf_ok_early", 32'(ok_to_if), 32'h0);
    tick();
    check("rf_ok", 32'(ok_to_if), 32'h1);
    check("rf_inst", inst_to_if, 32'hDEADBEEF);
    tick();
    enable_from_if = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the execute/fetch side and the byte-wide unified RAM. It arbitrates between instruction-fetch word reads and load/store requests from the load-store buffer (LSB), serialises each access into 1/2/4 single-byte RAM cycles, and returns assembled data with a one-cycle `ok` pulse. It also enforces I/O write back-pressure and aborts speculative reads on mispredict.

## Interface
Parameters:
- `IO_ADDR_MSB`, default 2'b11: value of `addr[17:16]` that marks the I/O region (0x30000 and above).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global ready; low means freeze.
- `mem_din` in 8: RAM read byte; valid the cycle after its address is presented.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: I/O sink cannot accept a byte.
- `enable_from_if` in 1: fetch read request, held until `ok_to_if`.
- `addr_from_if` in 32: fetch address; always a 4-byte read.
- `ok_to_if` out 1: one-cycle completion pulse.
- `inst_to_if` out 32: fetched word, valid while `ok_to_if` is high.
- `enable_from_lsb` in 1: LSB request, held until `ok_to_lsb`.
- `read_or_write_from_lsb` in 1: 0 = read, 1 = write.
- `addr_from_lsb` in 32: LSB byte address.
- `data_from_lsb` in 32: store data; low `width` bytes are used.
- `width_from_lsb` in 3: byte count, one of 1, 2 or 4.
- `ok_to_lsb` out 1: one-cycle completion pulse.
- `data_to_lsb` out 32: raw load data, zero-extended, valid with `ok_to_lsb`.
- `mispredict` in 1: flush speculative reads.

## Operation
- States:
  - IDLE: no access in progress.
  - READ: byte counter `cnt` runs 0..w.
  - WRITE: `cnt` runs 0..w-1.
- Request acceptance (IDLE only):
  - LSB has priority over fetch.
  - A client whose `ok` is currently high is ignored. Its `enable` is still high for that cycle and must not start a duplicate access.
  - The loser keeps its request pending.
- On accept, latch the address, width (4 for fetch), direction, data and client ID.
- I/O back-pressure: an LSB write with `addr[17:16]==IO_ADDR_MSB` is not accepted while `io_buffer_full` is high. The controller stays in IDLE, and fetch may be served meanwhile.
- Read, w bytes:
  - Issue addresses `addr`, `addr+1`, … on consecutive cycles with `mem_wr=0`.
  - Capture byte k from `mem_din` one cycle after its address, into bits [8k+7:8k]. Little-endian; unused upper bits are 0.
  - No sign extension; the LSB performs it.
- Write, w bytes:
  - Drive `mem_a=addr+k`, `mem_dout=data[8k+7:8k]`, `mem_wr=1` for k = 0..w-1 on consecutive cycles.
- Completion:
  - Return to IDLE and pulse the client's `ok` for exactly one cycle.
  - `mem_wr` returns to 0 and `mem_a` to 0 at the same edge.
- Mispredict:
  - An in-flight read (fetch or LSB) is abandoned: go to IDLE, `mem_wr=0`, no `ok`.
  - This applies even if the abandoning edge would have completed the read.
  - In IDLE, no request is accepted on a mispredict edge.
  - An in-flight write always completes and pulses `ok_to_lsb`, because stores are committed.
- `rdy` low: all registers hold; `mem_wr` is forced to 0 combinationally. Operation resumes exactly where it stopped.
- Address arithmetic is 32-bit, and `addr+k` wraps modulo 2^32.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `cnt=0`. All outputs are 0: `mem_a`, `mem_dout`, `mem_wr`, `ok_to_if`, `ok_to_lsb`, `inst_to_if`, `data_to_lsb`.
- All outputs are registered except the `rdy` gating of `mem_wr`.
- Let edge E0 be the edge that samples and accepts a request.
  - Read of w bytes: `mem_a=addr` in the cycle after E0. The last byte is captured at edge E(w+1), where `ok` rises. Example: LW, `ok` is high in the cycle after E5.
  - Write of w bytes: bytes occupy the w cycles after E0..E(w-1). `ok` rises at E(w). Example: SW, `ok` is high in the cycle after E4.
- Back-to-back: during the `ok` cycle the controller is in IDLE and may accept the other client at that edge. The same client is re-accepted no earlier than one cycle after its `ok`.
- `enable` dropping mid-access is not legal, except when it follows mispredict.

## Test plan
- Reset: drive `rst` low mid-write, then release → `mem_wr=0`, `ok` outputs 0, IDLE; a subsequent fetch of 0x0 completes normally.
- LSB LW at 0x1000, RAM bytes 11 22 33 44 → reads issued to 0x1000–0x1003; `data_to_lsb=0x44332211`; `ok_to_lsb` high for 1 cycle, 5 edges after accept; no second access while `enable` is still high.
- LSB SB 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles → no `mem_wr` during the stall; then exactly one write cycle, `mem_a=0x30000`, `mem_dout=0x41`, followed by `ok_to_lsb`.
- Fetch (0x0) and LSB LH (0x2000) requested simultaneously → LSB served first, `ok_to_lsb` 3 edges after accept; fetch accepted at the edge ending that `ok` cycle, with `inst_to_if` correct.
- `mispredict` at edge E2 of a fetch read → no `ok_to_if`, IDLE; with `mispredict` at E1 of an SW 0xAABBCCDD → all four bytes DD CC BB AA are written and `ok_to_lsb` pulses.
- `rdy` low for 2 cycles in the middle of an LW → `mem_wr=0`, state held; the result is identical to the uninterrupted run, delayed by 2 cycles.
